shift_issue: RTL and testbench
==============================

# shift_issue

Request front-end for the 32-bit barrel shifter chain. Accepts shift requests over a valid/ready handshake, buffers up to two in a small FIFO, and drives the first shifter stage (the 16-bit stage) and the rest of the chain. It decodes direction, per-stage amount bits and the arithmetic fill flag (neg) once, at accept time, so every downstream stage sees stable, registered controls.

## Interface
- WIDTH, 32, data width of shift operand
- AMT_W, 5, shift-amount width; bit k enables the 2**k stage
- DEPTH, 2, request FIFO entries (fixed at 2 for this revision)

- CLK  in  1  rising-edge clock, single clock domain
- RESET_N  in  1  asynchronous, active-low reset
- REQ_VALID  in  1  upstream request present
- REQ_READY  out  1  block can accept a request this cycle
- REQ_DATA  in  WIDTH  operand
- REQ_AMT  in  AMT_W  shift amount, 0..31
- REQ_DIR  in  1  1 = right, 0 = left
- REQ_ARITH  in  1  1 = arithmetic right (sign fill); ignored for left
- FLUSH  in  1  synchronous discard of all buffered requests
- ISS_VALID  out  1  head request presented to shifter chain
- ISS_READY  in  1  chain consumer accepts head this cycle
- ISS_DATA  out  WIDTH  operand to 16-bit stage INPUT
- ISS_AMT  out  AMT_W  per-stage enables; ISS_AMT[4] drives 16-bit stage AMT_n
- ISS_DIR  out  1  drives every stage SH_DIR
- ISS_NEG  out  1  drives every stage neg
- ISS_ZERO  out  1  head amount is 0 (pass-through)
- COUNT  out  2  FIFO occupancy 0..2
- ISS_CNT  out  16  number of requests issued since reset, wraps

## Operation
- Push: REQ_VALID && REQ_READY. Pop: ISS_VALID && ISS_READY.
- REQ_READY = (COUNT != 2), independent of ISS_READY. There is no push-through when full.
- Fields are decoded at push and stored per entry:
  - NEG = REQ_DIR & REQ_ARITH & REQ_DATA[WIDTH-1]
  - ZERO = (REQ_AMT == 0)
  - DATA, AMT and DIR are stored unchanged.
- Left shifts always store NEG=0.
- Occupancy FSM has three states: EMPTY, ONE, FULL.
  - EMPTY: push goes to ONE.
  - ONE: push alone goes to FULL; pop alone goes to EMPTY; push and pop together stay in ONE (the new entry becomes head).
  - FULL: pop goes to ONE. Push is impossible because ready is low.
- Order is strict FIFO.
- The head entry drives the ISS_* outputs from registers. ISS_VALID = (state != EMPTY).
- While ISS_VALID is high and ISS_READY is low, all ISS_* fields hold stable.
- ISS_CNT increments by 1 on each pop and wraps from 0xFFFF to 0x0000.
- FLUSH goes to EMPTY next cycle. It overrides push and pop in the same cycle: the accepted request is dropped and ISS_CNT is not incremented. REQ_READY is still driven normally during FLUSH.
- When the state is EMPTY, ISS_* data outputs hold their last value. They are don't-care, but must not be X after reset.

## Timing
- Reset (RESET_N low, asynchronous) sets:
  - state EMPTY, COUNT=0, ISS_VALID=0, REQ_READY=1 after release
  - ISS_DATA=0, ISS_AMT=0, ISS_DIR=0, ISS_NEG=0, ISS_ZERO=0, ISS_CNT=0
- Latency: a request pushed at edge N appears on ISS_* after edge N (ISS_VALID high in cycle N+1), when the FIFO was empty.
- Throughput: one request per cycle while ISS_READY stays high.
- REQ_READY deasserts the cycle after the second entry is written. It reasserts the cycle after a pop from FULL.
- Reset asserted mid-operation drops all entries immediately and does not wait for a clock edge.
- COUNT and ISS_VALID are registered outputs. They have no combinational path from REQ_VALID or ISS_READY.

## Structure
- The shared package shift_pkg holds:
  - WIDTH and AMT_W constants
  - SH_LEFT=0 and SH_RIGHT=1
  - a shift_req_t struct (data, amt, dir, neg, zero)
  - an occ_state_t enum (EMPTY, ONE, FULL)
- The 16-bit and other shifter stages import the same direction constants.
- One sub-module, shift_req_fifo, is natural. It is the 2-entry storage with read/write pointers, parameterised on shift_req_t. shift_issue holds the decode, FSM, FLUSH handling and ISS_CNT.

## Test plan
- Reset then single request: DATA=0x8000_0000, AMT=16, DIR=1, ARITH=1 -> next cycle ISS_VALID=1, ISS_AMT=5'b10000, ISS_NEG=1, ISS_ZERO=0, COUNT=1.
- Backpressure fill: ISS_READY=0 and push 0x0000_00F0 (left, AMT=4) then 0x1234_5678 (right logical, AMT=1) -> COUNT=2, REQ_READY=0, head stable at 0x0000_00F0 with ISS_NEG=0; raise ISS_READY -> pops in order, ISS_CNT=2.
- Streaming: 10 back-to-back requests with ISS_READY=1 -> one ISS_VALID beat per cycle, COUNT stays 1, ISS_CNT=10.
- Simultaneous push and pop in state ONE -> COUNT stays 1 and the new entry is at the head next cycle; AMT=0 request -> ISS_ZERO=1.
- FLUSH while FULL with a concurrent push -> next cycle COUNT=0, ISS_VALID=0, REQ_READY=1, ISS_CNT unchanged.
- RESET_N pulsed low between clock edges while FULL -> outputs reach reset values immediately; ISS_CNT=0.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: shared constants, request record and occupancy states for the shifter chain.
package shift_pkg;
    localparam int WIDTH = 32;
    localparam int AMT_W = 5;
    localparam logic SH_LEFT  = 1'b0;
    localparam logic SH_RIGHT = 1'b1;
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [AMT_W-1:0] amt;
        logic             dir;
        logic             neg;
        logic             zero;
    } shift_req_t;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} occ_state_t;
endpackage

// File: rtl/shift_req_fifo.sv
// shift_req_fifo: 2-entry request storage with read/write pointers.
module shift_req_fifo
    import shift_pkg::*;
#(
    parameter type T = shift_req_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic push,
    input  logic pop,
    input  logic empty,
    input  T     wdata,
    output T     rdata
);
    T     mem [2];
    logic rptr, wptr;
    // When empty the slot behind rptr is the last head, so outputs hold their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rptr   <= 1'b0;
            wptr   <= 1'b0;
        end else if (clr) begin
            rptr <= ~rptr;
            wptr <= ~rptr;
        end else begin
            if (push) mem[wptr] <= wdata;
            wptr <= wptr ^ push;
            rptr <= rptr ^ pop;
        end
    end
    assign rdata = empty ? mem[~rptr] : mem[rptr];
endmodule

// File: rtl/shift_issue.sv
// shift_issue: request front-end for the barrel shifter chain; decodes at accept,
// buffers two requests and issues the head with registered controls.
module shift_issue
    import shift_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [AMT_W-1:0] req_amt,
    input  logic             req_dir,
    input  logic             req_arith,
    input  logic             flush,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [WIDTH-1:0] iss_data,
    output logic [AMT_W-1:0] iss_amt,
    output logic             iss_dir,
    output logic             iss_neg,
    output logic             iss_zero,
    output logic [1:0]       count,
    output logic [15:0]      iss_cnt
);
    occ_state_t state_q, state_d;
    logic       push, pop;
    shift_req_t wr, head;
    assign req_ready = state_q != FULL;
    assign iss_valid = state_q != EMPTY;
    assign count     = state_q;
    assign push      = req_valid & req_ready;
    assign pop       = iss_valid & iss_ready;
    assign wr = '{data: req_data, amt: req_amt, dir: req_dir,
                  neg: (req_dir == SH_RIGHT) & req_arith & req_data[WIDTH-1],
                  zero: req_amt == '0};
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   state_d = push ? ONE : EMPTY;
            ONE:     state_d = (push == pop) ? ONE : (push ? FULL : EMPTY);
            FULL:    state_d = pop ? ONE : FULL;
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            iss_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (pop && !flush) iss_cnt <= iss_cnt + 16'd1;
        end
    end
    // Flush is gated off in EMPTY so the held head value is not disturbed.
    shift_req_fifo #(.T(shift_req_t)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush && iss_valid),
        .push  (push && !flush),
        .pop   (pop && !flush),
        .empty (!iss_valid),
        .wdata (wr),
        .rdata (head)
    );
    assign iss_data = head.data;
    assign iss_amt  = head.amt;
    assign iss_dir  = head.dir;
    assign iss_neg  = head.neg;
    assign iss_zero = head.zero;
endmodule

// File: tb/tb_shift_issue.sv
// tb_shift_issue: table-driven vectors plus a queue scoreboard for shift_issue.
module tb_shift_issue;
    import shift_pkg::*;
    typedef struct {
        logic [31:0] d;
        logic [4:0]  a;
        logic        dir;
        logic        ar;
        logic        neg;
        logic        zero;
    } vec_t;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_dir = 1'b0, req_arith = 1'b0, flush = 1'b0, iss_ready = 1'b0;
    logic [31:0] req_data = '0;
    logic [4:0]  req_amt = '0;
    logic        req_ready, iss_valid, iss_dir, iss_neg, iss_zero;
    logic [31:0] iss_data;
    logic [4:0]  iss_amt;
    logic [1:0]  count;
    logic [15:0] iss_cnt;
    vec_t        cur;
    vec_t        sb[$];
    vec_t        stream[10];
    logic [15:0] exp_cnt = '0;
    bit          chk_en = 1'b0;
    int          n_chk = 0, n_pass = 0;
    shift_issue dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_amt(req_amt), .req_dir(req_dir), .req_arith(req_arith),
        .flush(flush), .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_data(iss_data),
        .iss_amt(iss_amt), .iss_dir(iss_dir), .iss_neg(iss_neg), .iss_zero(iss_zero),
        .count(count), .iss_cnt(iss_cnt)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask
    function automatic vec_t mk(input logic [31:0] d, input logic [4:0] a, input logic dir,
                                input logic ar, input logic neg, input logic zero);
        vec_t v;
        v.d = d; v.a = a; v.dir = dir; v.ar = ar; v.neg = neg; v.zero = zero;
        return v;
    endfunction
    task automatic drive(input vec_t v);
        cur = v;
        req_valid = 1'b1; req_data = v.d; req_amt = v.a; req_dir = v.dir; req_arith = v.ar;
    endtask
    task automatic idle();
        req_valid = 1'b0;
    endtask
    // Reference model: updated on the clock edge from the stimulus only.
    always @(posedge clk) begin
        int sz;
        if (rst_n && chk_en) begin
            sz = sb.size();
            if (flush) sb.delete();
            else begin
                if (iss_ready && sz != 0) begin
                    void'(sb.pop_front());
                    exp_cnt++;
                end
                if (req_valid && sz != 2) sb.push_back(cur);
            end
        end
    end
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            chk("count", 32'(count), 32'(sb.size()));
            chk("iss_valid", 32'(iss_valid), 32'(sb.size() != 0));
            chk("req_ready", 32'(req_ready), 32'(sb.size() != 2));
            chk("iss_cnt", 32'(iss_cnt), 32'(exp_cnt));
            if (sb.size() != 0) begin
                chk("iss_data", iss_data, sb[0].d);
                chk("iss_amt", 32'(iss_amt), 32'(sb[0].a));
                chk("iss_dir", 32'(iss_dir), 32'(sb[0].dir));
                chk("iss_neg", 32'(iss_neg), 32'(sb[0].neg));
                chk("iss_zero", 32'(iss_zero), 32'(sb[0].zero));
            end
        end
    end
    initial begin
        stream[0] = mk(32'hFFFF0000, 5'd8,  1'b1, 1'b1, 1'b1, 1'b0);
        stream[1] = mk(32'h7FFFFFFF, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0);
        stream[2] = mk(32'h80000001, 5'd0,  1'b0, 1'b1, 1'b0, 1'b1);
        stream[3] = mk(32'h80000000, 5'd0,  1'b1, 1'b1, 1'b1, 1'b1);
        stream[4] = mk(32'h80000000, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0);
        stream[5] = mk(32'h00000001, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0);
        stream[6] = mk(32'hA5A5A5A5, 5'd5,  1'b1, 1'b1, 1'b1, 1'b0);
        stream[7] = mk(32'h5A5A5A5A, 5'd2,  1'b1, 1'b1, 1'b0, 1'b0);
        stream[8] = mk(32'hFFFFFFFF, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0);
        stream[9] = mk(32'hC0000000, 5'd31, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_iss_valid", 32'(iss_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_iss_data", iss_data, 32'd0);
        chk("rst_iss_amt", 32'(iss_amt), 32'd0);
        chk("rst_iss_flags", 32'({iss_dir, iss_neg, iss_zero}), 32'd0);
        chk("rst_iss_cnt", 32'(iss_cnt), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        // single arithmetic right request
        drive(mk(32'h80000000, 5'd16, 1'b1, 1'b1, 1'b1, 1'b0));
        @(negedge clk);
        idle();
        chk("t1_valid", 32'(iss_valid), 32'd1);
        chk("t1_amt", 32'(iss_amt), 32'h10);
        chk("t1_neg", 32'(iss_neg), 32'd1);
        chk("t1_zero", 32'(iss_zero), 32'd0);
        chk("t1_count", 32'(count), 32'd1);
        iss_ready = 1'b1;
        @(negedge clk);
        chk("t1_cnt", 32'(iss_cnt), 32'd1);
        iss_ready = 1'b0;
        // backpressure fill, third request must be refused
        drive(mk(32'h000000F0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        drive(mk(32'h12345678, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        drive(mk(32'hDEADBEEF, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0));
        @(negedge clk);
        chk("t2_count", 32'(count), 32'd2);
        chk("t2_ready", 32'(req_ready), 32'd0);
        chk("t2_head", iss_data, 32'h000000F0);
        chk("t2_neg", 32'(iss_neg), 32'd0);
        idle();
        iss_ready = 1'b1;
        @(negedge clk);
        chk("t2_second", iss_data, 32'h12345678);
        @(negedge clk);
        chk("t2_cnt", 32'(iss_cnt), 32'd3);
        chk("t2_empty", 32'(count), 32'd0);
        // streaming
        for (int i = 0; i < 10; i++) begin
            drive(stream[i]);
            @(negedge clk);
            chk("t3_count", 32'(count), 32'd1);
            chk("t3_head", iss_data, stream[i].d);
        end
        idle();
        @(negedge clk);
        chk("t3_cnt", 32'(iss_cnt), 32'd13);
        // push and pop together in ONE
        iss_ready = 1'b0;
        drive(mk(32'h11111111, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        iss_ready = 1'b1;
        drive(mk(32'h22222222, 5'd0, 1'b1, 1'b1, 1'b0, 1'b1));
        @(negedge clk);
        idle();
        chk("t4_count", 32'(count), 32'd1);
        chk("t4_head", iss_data, 32'h22222222);
        chk("t4_zero", 32'(iss_zero), 32'd1);
        @(negedge clk);
        chk("t4_cnt", 32'(iss_cnt), 32'd15);
        // flush while FULL
        iss_ready = 1'b0;
        drive(mk(32'h33333333, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        drive(mk(32'h44444444, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        drive(mk(32'h55555555, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0));
        flush = 1'b1;
        iss_ready = 1'b1;
        chk("t5_ready_full", 32'(req_ready), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        idle();
        iss_ready = 1'b0;
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_valid", 32'(iss_valid), 32'd0);
        chk("t5_ready", 32'(req_ready), 32'd1);
        chk("t5_cnt", 32'(iss_cnt), 32'd15);
        // flush in ONE with push and pop in the same cycle
        drive(mk(32'h66666666, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        drive(mk(32'h77777777, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0));
        flush = 1'b1;
        iss_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        idle();
        iss_ready = 1'b0;
        chk("t5b_count", 32'(count), 32'd0);
        chk("t5b_cnt", 32'(iss_cnt), 32'd15);
        // asynchronous reset between edges while FULL
        drive(mk(32'h88888888, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0));
        @(negedge clk);
        drive(mk(32'h99999999, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0));
        @(negedge clk);
        idle();
        chk("t6_full", 32'(count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        exp_cnt = '0;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_valid", 32'(iss_valid), 32'd0);
        chk("t6_ready", 32'(req_ready), 32'd1);
        chk("t6_cnt", 32'(iss_cnt), 32'd0);
        chk("t6_data", iss_data, 32'd0);
        chk("t6_neg", 32'(iss_neg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(32'hABCD0123, 5'd12, 1'b0, 1'b1, 1'b0, 1'b0));
        @(negedge clk);
        idle();
        chk("t6_after", iss_data, 32'hABCD0123);
        iss_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_cnt_after", 32'(iss_cnt), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
